// File: rtl/branch_pkg.sv
// Shared constants for the PC unit: branch condition codes, FSM encoding
// and the instruction size in bytes.
package branch_pkg;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_GTZ = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;

  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator driven by the ALU zero/sign flags.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] branch_cond,
  input  logic       zero,
  input  logic       neg,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_cond)
      BR_EQ:   cond = zero;
      BR_NE:   cond = !zero;
      BR_LEZ:  cond = neg | zero;
      BR_GTZ:  cond = !neg & !zero;
      BR_LTZ:  cond = neg;
      BR_GEZ:  cond = !neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Registered program counter with next-PC selection, RUN/HALTED FSM and
// optional branch statistics counters (enabled by defining BRANCH_STATS_EN).
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    IMM_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter int                    STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  branch,
  input  logic [2:0]            branch_cond,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  jump,
  input  logic                  jump_reg,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [25:0]           jump_index,
  input  logic [PC_WIDTH-1:0]   reg_target,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pc_plus4,
  output logic                  taken,
  output logic                  misaligned,
  output logic                  halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] taken_count
`endif
);

  pc_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic                  cond;
  logic                  active;
  logic signed [PC_WIDTH-1:0] imm_sext;
  logic [PC_WIDTH-1:0]   br_off, br_target, j_target, jr_target;

  branch_cond_eval u_cond (
    .branch_cond (branch_cond),
    .zero        (zero),
    .neg         (neg),
    .cond        (cond)
  );

  assign pc_plus4  = pc_q + PC_WIDTH'(INSTR_BYTES);
  assign imm_sext  = {{(PC_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign br_off    = {$unsigned(imm_sext[PC_WIDTH-3:0]), 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign jr_target = {reg_target[PC_WIDTH-1:2], 2'b00};

  // Region bits above 28 come from pc_plus4; this form stays legal at PC_WIDTH=28.
  always_comb begin
    j_target       = pc_plus4;
    j_target[27:0] = {jump_index, 2'b00};
  end

  assign active = (state_q == ST_RUN) && !halt && !stall;
  assign taken  = active && (jump_reg || jump || (branch && cond));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    if (state_q == ST_RUN) begin
      if (halt) begin
        state_d = ST_HALTED;
      end else if (!stall) begin
        mis_d = 1'b0;
        if (jump_reg) begin
          pc_d  = jr_target;
          mis_d = |reg_target[1:0];
        end else if (jump) begin
          pc_d = j_target;
        end else if (branch && cond) begin
          pc_d = br_target;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign misaligned = mis_q;
  assign halted     = (state_q == ST_HALTED);

`ifdef BRANCH_STATS_EN
  logic [STAT_WIDTH-1:0] bcnt_q, tcnt_q;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + STAT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else if (active && branch) begin
      bcnt_q <= sat_inc(bcnt_q);
      if (cond) tcnt_q <= sat_inc(tcnt_q);
    end
  end

  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;
`endif

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Parametrised successor to the combinational branch unit of the single-cycle processor.
- Owns the registered program counter. Each cycle it resolves next-PC from:
  - sequential fetch,
  - six conditional branch modes,
  - absolute jump,
  - jump-register,
  - stall,
  - halt.
- Sits between the control unit/ALU flags and the instruction memory address port.

Parameters:
- PC_WIDTH, 32, PC and address width in bits; must be >= 28.
- IMM_WIDTH, 16, branch offset width in words, sign-extended.
- RESET_PC, 0, PC value loaded on reset; must be word aligned.
- STAT_WIDTH, 16, width of the optional statistics counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC this cycle
- halt  input  1  request permanent stop
- branch  input  1  current instruction is a conditional branch
- branch_cond  input  3  condition select, decoded from the BR_* codes below
- zero  input  1  ALU result == 0
- neg  input  1  ALU result sign bit
- jump  input  1  absolute jump (J/JAL)
- jump_reg  input  1  register jump (JR)
- imm  input  IMM_WIDTH  signed word offset
- jump_index  input  26  J-format target field
- reg_target  input  PC_WIDTH  register value for JR
- pc  output  PC_WIDTH  current PC, registered
- pc_plus4  output  PC_WIDTH  pc+4, combinational
- taken  output  1  a redirect is selected this cycle, combinational
- misaligned  output  1  registered; set when a JR target has nonzero bits [1:0]
- halted  output  1  registered; FSM is in HALTED
- branch_count  output  STAT_WIDTH  present only with the optional feature
- taken_count  output  STAT_WIDTH  present only with the optional feature

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, misaligned=0, halted=0, FSM=RUN.
  - Counters = 0.
  - Deassertion is sampled synchronously; the first update occurs on the first clk edge with rst_n=1.
- FSM states: RUN, HALTED.
  - RUN -> HALTED on a clk edge with halt=1. pc holds on that edge.
  - HALTED is exited only by reset. In HALTED: pc holds, taken=0, all inputs are ignored.
- Branch condition codes (branch_cond):
  - BR_EQ=0: zero
  - BR_NE=1: !zero
  - BR_LEZ=2: neg|zero
  - BR_GTZ=3: !neg&!zero
  - BR_LTZ=4: neg
  - BR_GEZ=5: !neg
  - Codes 6 and 7: never taken.
- Targets:
  - Branch target = pc_plus4 + (sext(imm)<<2), computed modulo 2^PC_WIDTH (wrap, no overflow flag).
  - Jump target = {pc_plus4[PC_WIDTH-1:28], jump_index, 2'b00}.
  - JR target = {reg_target[PC_WIDTH-1:2], 2'b00}.
- Next-PC priority, RUN state, per clk edge (highest first):
  1. halt: hold.
  2. stall: hold; the misaligned flag is unchanged.
  3. jump_reg: JR target; misaligned <= |reg_target[1:0].
  4. jump: jump target.
  5. branch and condition true: branch target.
  6. Otherwise: pc_plus4.
  - Misaligned update rule: any edge that updates pc without jump_reg clears misaligned; any edge that holds pc leaves it unchanged.
- taken = RUN & !halt & !stall & (jump_reg | jump | (branch & cond)).
- Simultaneous jump and branch: jump wins; the branch condition is ignored.
- pc_plus4 wraps from all-ones-minus-3 to 0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - branch_count increments on each non-held RUN edge with branch=1.
  - taken_count increments on each such edge where the branch is taken.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the counter ports and logic are absent.

Decomposition:
- Shared package branch_pkg holds:
  - BR_* condition codes (3-bit localparams),
  - FSM state encodings,
  - the INSTR_BYTES=4 constant.
- One natural sub-module: branch_cond_eval, combinational; inputs branch_cond, zero, neg; output cond.

Test Plan:
- Reset then 3 free-running edges -> pc = 0x0, 0x4, 0x8, 0xC; taken=0.
- pc=0x10, branch=1, cond=BR_EQ, zero=1, imm=16'h0001 -> next pc=0x18. Same stimulus with zero=0 -> next pc=0x14.
- pc=0x100, branch=1, cond=BR_LTZ, neg=1, imm=16'hFFFE -> next pc=0xFC.
- pc=0x40, jump=1, branch=1 (condition true), jump_index=26'h10 -> next pc=0x40 (jump wins). Then jump_reg=1, reg_target=0x203 -> pc=0x200, misaligned=1.
- stall=1 for 2 edges at pc=0x8 -> pc stays 0x8. Then halt=1 -> halted=1 and pc frozen for 5 edges despite jump=1. rst_n pulse low mid-cycle -> pc=RESET_PC immediately.
- With BRANCH_STATS_EN: 3 branches (2 taken) plus 1 stalled branch -> branch_count=3, taken_count=2. Preload near saturation via a small STAT_WIDTH=2 build -> counter holds at 3.
